// File: rtl/cla_seq_pkg.sv
// rtl/cla_seq_pkg.sv - shared types and constants for the sequential CLA adder
package cla_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } cla_seq_state_t;

  localparam int NIBBLE_W = 4;

endpackage

// File: rtl/cla4badd.sv
// rtl/cla4badd.sv - 4-bit carry-lookahead adder, sum[4] is the carry-out
module cla4badd (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [4:0] sum
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Generate/propagate terms and flattened lookahead carries
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = {c[4], p ^ c[3:0]};
  end

endmodule

// File: rtl/cla_seq_adder.sv
// rtl/cla_seq_adder.sv - nibble-serial WIDTH-bit adder; CLA_SEQ_SUB_EN adds subtract and overflow
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
`ifdef CLA_SEQ_SUB_EN
  ,
  input  logic             in_sub,
  output logic             out_ovf
`endif
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  if ((WIDTH % NIBBLE_W) != 0 || WIDTH < NIBBLE_W) begin : g_bad_width
    $error("cla_seq_adder: WIDTH must be a positive multiple of 4");
  end

  cla_seq_state_t   state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_cout_q, out_cout_d;
  logic             out_valid_q, out_valid_d;
  logic             sub_sel;
  logic [4:0]       nib_sum;

`ifdef CLA_SEQ_SUB_EN
  logic out_ovf_q, out_ovf_d;
  assign sub_sel = in_sub;
  assign out_ovf = out_ovf_q;
`else
  assign sub_sel = 1'b0;
`endif

  // Operands are right-shifted each CALC cycle so the low nibble is always the active one
  cla4badd u_cla4badd (
    .a   (a_q[NIBBLE_W-1:0]),
    .b   (b_q[NIBBLE_W-1:0]),
    .cin (carry_q),
    .sum (nib_sum)
  );

  assign in_ready  = (state_q == IDLE) && !rst;
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;

  // Next-state logic: accept in IDLE, one nibble per CALC cycle, hold result in DONE
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;
    out_valid_d = out_valid_q;
`ifdef CLA_SEQ_SUB_EN
    out_ovf_d   = out_ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = sub_sel ? ~in_b : in_b;
          carry_d = sub_sel ? 1'b1 : in_cin;
          idx_d   = '0;
          acc_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        a_d     = a_q >> NIBBLE_W;
        b_d     = b_q >> NIBBLE_W;
        carry_d = nib_sum[4];
        // New nibble enters at the top; after NIB shifts nibble 0 sits at the bottom
        acc_d   = (acc_q >> NIBBLE_W) | (WIDTH'(nib_sum[3:0]) << (WIDTH - NIBBLE_W));
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          idx_d       = '0;
          state_d     = DONE;
          out_valid_d = 1'b1;
          out_sum_d   = acc_d;
          out_cout_d  = nib_sum[4];
`ifdef CLA_SEQ_SUB_EN
          // Carry into the MSB xor carry out of the MSB
          out_ovf_d   = a_q[NIBBLE_W-1] ^ b_q[NIBBLE_W-1] ^ nib_sum[NIBBLE_W-1] ^ nib_sum[4];
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset discards any in-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef CLA_SEQ_SUB_EN
      out_ovf_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      out_valid_q <= out_valid_d;
`ifdef CLA_SEQ_SUB_EN
      out_ovf_q   <= out_ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_cla_seq_adder.sv
// tb/tb_cla_seq_adder.sv - directed and random checks of cla_seq_adder at WIDTH 16 and 4
module tb_cla_seq_adder;

  logic clk = 1'b0;
  logic rst;

  logic [15:0] a16, b16, s16;
  logic        cin16, iv16, or16, ir16, ov16, co16, busy16;
  logic [3:0]  a4, b4, s4;
  logic        cin4, iv4, or4, ir4, ov4, co4, busy4;
`ifdef CLA_SEQ_SUB_EN
  logic        sub16, ovf16, sub4, ovf4;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  cla_seq_adder #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv16),
    .in_ready  (ir16),
    .in_a      (a16),
    .in_b      (b16),
    .in_cin    (cin16),
    .out_valid (ov16),
    .out_ready (or16),
    .out_sum   (s16),
    .out_cout  (co16),
    .busy      (busy16)
`ifdef CLA_SEQ_SUB_EN
    ,
    .in_sub    (sub16),
    .out_ovf   (ovf16)
`endif
  );

  cla_seq_adder #(.WIDTH(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv4),
    .in_ready  (ir4),
    .in_a      (a4),
    .in_b      (b4),
    .in_cin    (cin4),
    .out_valid (ov4),
    .out_ready (or4),
    .out_sum   (s4),
    .out_cout  (co4),
    .busy      (busy4)
`ifdef CLA_SEQ_SUB_EN
    ,
    .in_sub    (sub4),
    .out_ovf   (ovf4)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One WIDTH=16 operation: accept, count edges to out_valid, stall, then consume
  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic cin,
                      input logic sub, input int stall,
                      output logic [16:0] res, output logic ovf, output int lat);
    @(negedge clk);
    chk("op16_in_ready", {31'd0, ir16}, 32'd1);
    a16 = a; b16 = b; cin16 = cin; iv16 = 1'b1;
`ifdef CLA_SEQ_SUB_EN
    sub16 = sub;
`endif
    @(posedge clk);
    @(negedge clk);
    iv16 = 1'b0;
    lat  = 0;
    while (!ov16 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = {co16, s16};
`ifdef CLA_SEQ_SUB_EN
    ovf = ovf16;
    sub16 = 1'b0;
`else
    ovf = sub;
`endif
    repeat (stall) @(negedge clk);
    or16 = 1'b1;
    @(negedge clk);
    or16 = 1'b0;
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic cin, input int stall,
                     output logic [4:0] res, output int lat);
    @(negedge clk);
    chk("op4_in_ready", {31'd0, ir4}, 32'd1);
    a4 = a; b4 = b; cin4 = cin; iv4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv4 = 1'b0;
    lat = 0;
    while (!ov4 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    res = {co4, s4};
    repeat (stall) @(negedge clk);
    or4 = 1'b1;
    @(negedge clk);
    or4 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [16:0] res;
    logic [4:0]  res4;
    logic        ovf;
    int          lat;
    logic [15:0] ra, rb;
    logic [3:0]  ra4, rb4;
    logic        rc;

    rst = 1'b1;
    a16 = '0; b16 = '0; cin16 = 1'b0; iv16 = 1'b0; or16 = 1'b0;
    a4 = '0; b4 = '0; cin4 = 1'b0; iv4 = 1'b0; or4 = 1'b0;
`ifdef CLA_SEQ_SUB_EN
    sub16 = 1'b0; sub4 = 1'b0;
`endif

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready_low", {31'd0, ir16}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst16_state", {11'd0, ov16, ir16, busy16, co16, s16}, {11'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000});
    chk("rst4_state", {23'd0, ov4, ir4, busy4, co4, s4}, {23'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0});

    // 1: full carry ripple, latency 4
    op16(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, res, ovf, lat);
    chk("t1_result", {15'd0, res}, {15'd0, 17'h10000});
    chk("t1_latency", lat, 4);

    // 2: carry-in crosses three nibbles
    op16(16'h0FFF, 16'h0000, 1'b1, 1'b0, 2, res, ovf, lat);
    chk("t2_result", {15'd0, res}, {15'd0, 17'h01000});

    // 3: backpressure holds outputs and blocks a second operation
    @(negedge clk);
    a16 = 16'h00AA; b16 = 16'h0055; cin16 = 1'b0; iv16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv16 = 1'b0;
    lat = 0;
    while (!ov16 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("t3_latency", lat, 4);
    a16 = 16'hFFFF; b16 = 16'hFFFF; iv16 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      chk("t3_hold", {13'd0, ov16, ir16, co16, s16}, {13'd0, 1'b1, 1'b0, 1'b0, 16'h00FF});
      @(negedge clk);
    end
    iv16 = 1'b0;
    or16 = 1'b1;
    @(negedge clk);
    or16 = 1'b0;
    chk("t3_released", {29'd0, ov16, busy16, ir16}, {29'd0, 1'b0, 1'b0, 1'b1});
    @(negedge clk);
    chk("t3_no_second_accept", {31'd0, busy16}, 32'd0);

    // 4: reset while processing nibble 2
    a16 = 16'hAAAA; b16 = 16'h5555; cin16 = 1'b1; iv16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv16 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t4_after_rst", {11'd0, ov16, ir16, busy16, co16, s16}, {11'd0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000});
    op16(16'h1234, 16'h4321, 1'b0, 1'b0, 0, res, ovf, lat);
    chk("t4_result", {15'd0, res}, {15'd0, 17'h05555});
    chk("t4_latency", lat, 4);

`ifdef CLA_SEQ_SUB_EN
    // 5: subtract and signed overflow
    op16(16'h0005, 16'h0007, 1'b0, 1'b1, 0, res, ovf, lat);
    chk("t5_sub_result", {15'd0, res}, {15'd0, 17'h0FFFE});
    chk("t5_sub_ovf", {31'd0, ovf}, 32'd0);
    op16(16'h8000, 16'h0001, 1'b0, 1'b1, 1, res, ovf, lat);
    chk("t5_ovf_result", {15'd0, res}, {15'd0, 17'h17FFF});
    chk("t5_ovf_flag", {31'd0, ovf}, 32'd1);
    op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0, res, ovf, lat);
    chk("t5_add_ovf", {15'd0, res, ovf}, {15'd0, 17'h08000, 1'b1});
`endif

    // WIDTH=4 directed: single CALC cycle
    op4(4'hF, 4'h1, 1'b0, 0, res4, lat);
    chk("w4_wrap", {27'd0, res4}, {27'd0, 5'h10});
    chk("w4_latency", lat, 1);
    op4(4'h7, 4'h8, 1'b1, 3, res4, lat);
    chk("w4_cin", {27'd0, res4}, {27'd0, 5'h10});

    // 6: random operations with random consumer stalls
    for (int i = 0; i < 100; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      op16(ra, rb, rc, 1'b0, int'($urandom_range(0, 3)), res, ovf, lat);
      chk("rand16", {15'd0, res}, {15'd0, 17'(ra) + 17'(rb) + 17'(rc)});
    end
    for (int i = 0; i < 100; i++) begin
      ra4 = 4'($urandom);
      rb4 = 4'($urandom);
      rc  = 1'($urandom);
      op4(ra4, rb4, rc, int'($urandom_range(0, 3)), res4, lat);
      chk("rand4", {27'd0, res4}, {27'd0, 5'(ra4) + 5'(rb4) + 5'(rc)});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
